// File: rtl/aes_round_sequencer.sv
// Round sequencer for an iterative AES-128 datapath: accepts a plaintext block,
// walks Round_Number 0..10 one round per cycle through the external datapath, then holds the ciphertext.
module aes_round_sequencer #(
  parameter int BYTE     = 8,
  parameter int WORD     = 32,
  parameter int SENTENCE = 128
) (
  input  logic                clk,
  input  logic                rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // A producer holds valid and data until that edge; ready never depends on valid.
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SENTENCE-1:0] in_data,
  output logic [3:0]          Round_Number,
  output logic [SENTENCE-1:0] state_out,
  input  logic [SENTENCE-1:0] round_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SENTENCE-1:0] out_data,
  output logic                busy,
  output logic [1:0]          fsm_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [3:0] NO_ROUND   = 4'hF;

  // The datapath slices the block into words and bytes; reject geometries it cannot split evenly.
  if ((SENTENCE % WORD) != 0 || (WORD % BYTE) != 0) begin : g_bad_geometry
    $error("aes_round_sequencer: SENTENCE must be a multiple of WORD and WORD of BYTE");
  end

  fsm_e                state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [SENTENCE-1:0] sreg_q, sreg_d;
  logic [SENTENCE-1:0] odata_q, odata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sreg_q  <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      odata_q <= odata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == LAST_ROUND) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The last round's result goes straight to out_data; the state register keeps round 9's value.
  always_comb begin
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    odata_d = odata_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d = in_data;
          cnt_d  = 4'd0;
        end
      end
      RUN: begin
        if (cnt_q == LAST_ROUND) begin
          odata_d = round_result;
        end else begin
          sreg_d = round_result;
          cnt_d  = cnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    Round_Number = NO_ROUND;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      RUN:     Round_Number = cnt_q;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign state_out   = sreg_q;
  assign out_data    = odata_q;
  assign fsm_state_o = state_q;

  a_cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= LAST_ROUND);
  a_state_legal:  assert property (@(posedge clk) disable iff (rst) state_q != 2'd3);

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter BYTE, default 8, byte width in bits.
REQ-002 SHALL have parameter WORD, default 32, word width in bits.
REQ-003 SHALL have parameter SENTENCE, default 128, AES state/block width in bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: plaintext block offered.
REQ-007 SHALL have port in_ready, output, 1 bit: sequencer can accept a block.
REQ-008 SHALL have port in_data, input, SENTENCE bits: plaintext block.
REQ-009 SHALL have port Round_Number, output, 4 bits: round index driven to the round-input select mux and key schedule.
REQ-010 SHALL have port state_out, output, SENTENCE bits: current state register, fed to the datapath (round-0 and round inputs).
REQ-011 SHALL have port round_result, input, SENTENCE bits: combinational AddRoundKey output of the datapath for the current Round_Number.
REQ-012 SHALL have port out_valid, output, 1 bit: ciphertext available.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts ciphertext.
REQ-014 SHALL have port out_data, output, SENTENCE bits: ciphertext block.
REQ-015 SHALL have port busy, output, 1 bit: high in RUN or DONE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE, and SHALL NOT reach any other state.
REQ-017 In IDLE, SHALL assert in_ready=1; in RUN and DONE, in_ready=0.
REQ-018 IDLE->RUN on in_valid&&in_ready: state_reg<=in_data, round counter<=0.
REQ-019 In RUN, SHALL drive Round_Number=round counter (0..10); in IDLE/DONE, Round_Number=4'hF (out-of-range; downstream mux yields zero).
REQ-020 In RUN with counter<10, each cycle SHALL load state_reg<=round_result and increment the counter by 1.
REQ-021 In RUN with counter==10, SHALL load out_data<=round_result, leave state_reg unchanged, and go to DONE.
REQ-022 Counter SHALL never exceed 10; no wrap-around; 4-bit unsigned arithmetic.
REQ-023 RUN SHALL last exactly 11 cycles (Round_Number 0,1,...,10, one per cycle, no stalls).
REQ-024 out_valid SHALL be 1 exactly in DONE; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 DONE->IDLE on out_ready=1 (handshake completes that cycle); otherwise SHALL remain in DONE indefinitely.
REQ-026 in_valid in RUN or DONE SHALL be ignored (not latched, not queued).
REQ-027 out_ready while not in DONE SHALL have no effect.
REQ-028 Latency: if in handshake is at edge T, first out_valid=1 cycle SHALL follow edge T+11 (12 edges to DONE-reg visibility inclusive of accept).
REQ-029 state_out SHALL always equal state_reg (registered, no combinational path from inputs).
REQ-030 busy SHALL be high in RUN and DONE, low in IDLE.

Reset
REQ-031 On rst=1 at a clock edge, SHALL enter IDLE, counter=0, state_reg=0, out_data=0.
REQ-032 After reset, outputs SHALL be in_ready=1, out_valid=0, busy=0, Round_Number=4'hF, state_out=0, out_data=0.
REQ-033 rst SHALL take priority over all handshakes; reset during RUN or DONE SHALL abandon the block without emitting out_valid.

Verification
REQ-034 Reset then idle 5 cycles -> in_ready=1, out_valid=0, Round_Number=4'hF, state_out=0 every cycle.
REQ-035 Accept in_data=128'h00112233445566778899aabbccddeeff, datapath model round_result=state_out^{124'h0,Round_Number} -> Round_Number steps 0..10 on 11 consecutive cycles, out_valid after 11 RUN cycles, out_data=in_data^128'h0...0B (XOR of 0..10 = 4'hB in low nibble).
REQ-036 out_ready held 0 for 7 cycles in DONE -> out_valid=1, out_data constant, in_ready=0; raising out_ready -> IDLE next cycle, in_ready=1.
REQ-037 in_valid pulsed with different data at Round_Number=4 -> ignored; out_data matches first block only.
REQ-038 rst asserted when Round_Number=6 -> next cycle IDLE, state_out=0, Round_Number=4'hF, out_valid never asserted for that block.
REQ-039 Back-to-back blocks with out_ready=1 and in_valid=1 constant -> one block per 13 cycles, each out_data correct per REQ-035 model.
